alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Collapsing, age-ordered issue queue for the ALU pipe, directly upstream of the execute stage. It holds dispatched ALU micro-ops until both source operands are available or forwardable, then selects the oldest ready entry into the execute-stage register. Readiness comes from the execute stage's wake broadcasts (producer ROB address plus valid). Operand values are not captured on wake. The issued entry carries per-operand forward-enable flags so execute takes the value from the forward network.

## Interface
Parameters:
- DEPTH, 8: number of queue entries (≥2).
- WAKE_NUM, 2: number of wake broadcast ports.
- ROB_AW, 6: ROB address (tag) width.
- PAYLOAD_W, 64: opaque ctl/imm/exception bits, passed through unchanged.

Ports (clk and resetn: one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch.
- disp_dst  in  ROB_AW  destination ROB address.
- disp_r1, disp_r2  in  ROB_AW  producer tags of the two sources.
- disp_rdy1, disp_rdy2  in  1  source value already valid in disp_src1/disp_src2.
- disp_src1, disp_src2  in  32  source values, meaningful when the matching rdy bit is 1.
- disp_payload  in  PAYLOAD_W  opaque payload.
- wake_valid  in  WAKE_NUM  wake broadcast valid.
- wake_id  in  WAKE_NUM*ROB_AW  wake broadcast tags; port k occupies bits [k*ROB_AW +: ROB_AW].
- iss_valid  out  1  selected entry presented.
- iss_ready  in  1  execute register accepts this cycle.
- iss_dst, iss_r1, iss_r2  out  ROB_AW  fields of the selected entry.
- iss_src1, iss_src2  out  32  captured source values.
- iss_fwd_en1, iss_fwd_en2  out  1  operand was satisfied by wake, not at dispatch.
- iss_payload  out  PAYLOAD_W  payload of the selected entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry state: valid, dst, r1/r2, rdy1/rdy2, fwd1/fwd2, src1/src2, payload. Index 0 is the oldest.
- Dispatch:
  - Fires when disp_valid && disp_ready.
  - Writes the entry at index count, or at count-1 if an issue fires in the same cycle.
  - fwdN = !disp_rdyN.
- Wake:
  - For each valid entry and each port k, set rdyN when wake_valid[k] && wake_id[k]==rN.
  - Dispatch-cycle wake also applies: a dispatched source whose tag matches a wake in the same cycle is stored with rdy=1 and fwd=1.
- Select:
  - The lowest-index valid entry with rdy1 && rdy2 whose ready bits were set before this cycle.
  - iss_* is driven combinationally from that entry.
  - iss_valid=0 when no entry qualifies; iss_* are then don't-care.
- Issue fires when iss_valid && iss_ready. The selected entry is removed, and all higher entries shift down by one, preserving age order.
- disp_ready = (count < DEPTH) && !flush. A same-cycle issue does not free a slot for a same-cycle dispatch while full.
- flush has priority:
  - All valid bits clear at the edge.
  - The dispatch in that cycle is dropped.
  - Issue handshakes in that cycle are ignored by this block; the downstream register flushes itself.
- count is updated as +dispatch −issue, saturating is not needed because disp_ready gates dispatch.

## Timing
- Reset: all valid=0, count=0, iss_valid=0, disp_ready=1.
- Dispatch at edge N with both rdy=1: entry can have iss_valid=1 in cycle N+1 (latency 1).
- Wake in cycle N: the entry becomes selectable in cycle N+1. With IQ_FAST_WAKE_EN, it is selectable in cycle N itself (see Configuration).
- No combinational path from iss_ready to disp_ready or iss_valid.
- Full (count==DEPTH): disp_ready=0 even if an issue fires; it reasserts the next cycle.
- Empty: iss_valid=0. A dispatch and a wake in the same cycle on an empty queue still capture the ready bit.
- Reset asserted mid-operation clears all state immediately, asynchronously.

## Configuration
- IQ_FAST_WAKE_EN defined:
  - An entry whose last outstanding operand matches a wake this cycle is selectable in the same cycle.
  - Its fwd flag is 1, giving back-to-back dependent ALU issue.
  - This adds the wake compare into the select path.
- Undefined: a woken entry waits one cycle, leaving one bubble between dependent ALU ops.

## Test plan
- Reset, then dispatch dst=5, rdy1=rdy2=1, src1=0x10, src2=0x20 → next cycle iss_valid=1, iss_dst=5, iss_src1=0x10, fwd_en1=fwd_en2=0; with iss_ready=1, count returns 0.
- Dispatch dst=7 with r1=3, rdy1=0, rdy2=1; wake_id[0]=3 two cycles later → iss_valid=1 one cycle after the wake (same cycle with IQ_FAST_WAKE_EN), iss_fwd_en1=1, iss_fwd_en2=0.
- Fill 8 ready entries dst=0..7 with iss_ready=0 → disp_ready=0, count=8. Then with iss_ready=1 → issue order 0,1,…,7, and disp_ready=1 the cycle after the first issue.
- Entries A (dst=1, waiting on tag 9) and B (dst=2, ready), A older → B issues first; wake tag 9 → A issues next; relative order of remaining entries unchanged.
- Dispatch with r2=4, rdy2=0 in the same cycle as wake_id[1]=4 → entry stored ready, issues next cycle with fwd_en2=1.
- Queue holding 3 entries; assert flush together with disp_valid=1 → next cycle count=0, iss_valid=0, and the dispatched op is absent.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Collapsing, age-ordered ALU issue queue: holds dispatched micro-ops until both
// operands are ready, then selects the oldest ready entry. Optional macro: IQ_FAST_WAKE_EN.
module alu_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WAKE_NUM  = 2,
  parameter int unsigned ROB_AW    = 6,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [ROB_AW-1:0]            disp_dst,
  input  logic [ROB_AW-1:0]            disp_r1,
  input  logic [ROB_AW-1:0]            disp_r2,
  input  logic                         disp_rdy1,
  input  logic                         disp_rdy2,
  input  logic [31:0]                  disp_src1,
  input  logic [31:0]                  disp_src2,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  input  logic [WAKE_NUM-1:0]          wake_valid,
  input  logic [WAKE_NUM*ROB_AW-1:0]   wake_id,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [ROB_AW-1:0]            iss_dst,
  output logic [ROB_AW-1:0]            iss_r1,
  output logic [ROB_AW-1:0]            iss_r2,
  output logic [31:0]                  iss_src1,
  output logic [31:0]                  iss_src2,
  output logic                         iss_fwd_en1,
  output logic                         iss_fwd_en2,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage, index 0 is the oldest
  logic                 q_valid   [DEPTH];
  logic [ROB_AW-1:0]    q_dst     [DEPTH];
  logic [ROB_AW-1:0]    q_r1      [DEPTH];
  logic [ROB_AW-1:0]    q_r2      [DEPTH];
  logic                 q_rdy1    [DEPTH];
  logic                 q_rdy2    [DEPTH];
  logic                 q_fwd1    [DEPTH];
  logic                 q_fwd2    [DEPTH];
  logic [31:0]          q_src1    [DEPTH];
  logic [31:0]          q_src2    [DEPTH];
  logic [PAYLOAD_W-1:0] q_payload [DEPTH];
  logic [CW-1:0]        count_q;

  // Post-wake view of each entry, with one extra invalid slot feeding the top on a shift
  logic                 w_valid   [DEPTH+1];
  logic [ROB_AW-1:0]    w_dst     [DEPTH+1];
  logic [ROB_AW-1:0]    w_r1      [DEPTH+1];
  logic [ROB_AW-1:0]    w_r2      [DEPTH+1];
  logic                 w_rdy1    [DEPTH+1];
  logic                 w_rdy2    [DEPTH+1];
  logic                 w_fwd1    [DEPTH+1];
  logic                 w_fwd2    [DEPTH+1];
  logic [31:0]          w_src1    [DEPTH+1];
  logic [31:0]          w_src2    [DEPTH+1];
  logic [PAYLOAD_W-1:0] w_payload [DEPTH+1];

  logic                 n_valid   [DEPTH];
  logic [ROB_AW-1:0]    n_dst     [DEPTH];
  logic [ROB_AW-1:0]    n_r1      [DEPTH];
  logic [ROB_AW-1:0]    n_r2      [DEPTH];
  logic                 n_rdy1    [DEPTH];
  logic                 n_rdy2    [DEPTH];
  logic                 n_fwd1    [DEPTH];
  logic                 n_fwd2    [DEPTH];
  logic [31:0]          n_src1    [DEPTH];
  logic [31:0]          n_src2    [DEPTH];
  logic [PAYLOAD_W-1:0] n_payload [DEPTH];
  logic [CW-1:0]        count_n;

  logic          hit1 [DEPTH];
  logic          hit2 [DEPTH];
  logic          elig [DEPTH];
  logic          disp_hit1;
  logic          disp_hit2;
  logic [IW-1:0] sel;
  logic          issue_fire;
  logic          disp_fire;
  logic [CW-1:0] wr_idx;

  assign disp_ready = (count_q < CW'(DEPTH)) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign issue_fire = iss_valid && iss_ready && !flush;
  assign wr_idx     = issue_fire ? (count_q - CW'(1)) : count_q;
  assign count      = count_q;

  // Wake tag compare against every stored source and the incoming dispatch
  always_comb begin
    disp_hit1 = 1'b0;
    disp_hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit1[i] = 1'b0;
      hit2[i] = 1'b0;
    end
    for (int k = 0; k < int'(WAKE_NUM); k++) begin
      if (wake_valid[k]) begin
        if (wake_id[k*ROB_AW +: ROB_AW] == disp_r1) disp_hit1 = 1'b1;
        if (wake_id[k*ROB_AW +: ROB_AW] == disp_r2) disp_hit2 = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (wake_id[k*ROB_AW +: ROB_AW] == q_r1[i]) hit1[i] = 1'b1;
          if (wake_id[k*ROB_AW +: ROB_AW] == q_r2[i]) hit2[i] = 1'b1;
        end
      end
    end
  end

  // Oldest-ready select
  always_comb begin
    sel       = '0;
    iss_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
`ifdef IQ_FAST_WAKE_EN
      elig[i] = q_valid[i] && (q_rdy1[i] || hit1[i]) && (q_rdy2[i] || hit2[i]);
`else
      elig[i] = q_valid[i] && q_rdy1[i] && q_rdy2[i];
`endif
      if (elig[i] && !iss_valid) begin
        iss_valid = 1'b1;
        sel       = IW'(i);
      end
    end
  end

  assign iss_dst     = q_dst[sel];
  assign iss_r1      = q_r1[sel];
  assign iss_r2      = q_r2[sel];
  assign iss_src1    = q_src1[sel];
  assign iss_src2    = q_src2[sel];
  assign iss_fwd_en1 = q_fwd1[sel];
  assign iss_fwd_en2 = q_fwd2[sel];
  assign iss_payload = q_payload[sel];

  // Next state: apply wakes, collapse over the issued slot, insert dispatch, then flush
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_valid[i]   = q_valid[i];
      w_dst[i]     = q_dst[i];
      w_r1[i]      = q_r1[i];
      w_r2[i]      = q_r2[i];
      w_rdy1[i]    = q_rdy1[i] | hit1[i];
      w_rdy2[i]    = q_rdy2[i] | hit2[i];
      w_fwd1[i]    = q_fwd1[i];
      w_fwd2[i]    = q_fwd2[i];
      w_src1[i]    = q_src1[i];
      w_src2[i]    = q_src2[i];
      w_payload[i] = q_payload[i];
    end
    w_valid[DEPTH]   = 1'b0;
    w_dst[DEPTH]     = '0;
    w_r1[DEPTH]      = '0;
    w_r2[DEPTH]      = '0;
    w_rdy1[DEPTH]    = 1'b0;
    w_rdy2[DEPTH]    = 1'b0;
    w_fwd1[DEPTH]    = 1'b0;
    w_fwd2[DEPTH]    = 1'b0;
    w_src1[DEPTH]    = '0;
    w_src2[DEPTH]    = '0;
    w_payload[DEPTH] = '0;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (issue_fire && (IW'(i) >= sel)) begin
        n_valid[i]   = w_valid[i+1];
        n_dst[i]     = w_dst[i+1];
        n_r1[i]      = w_r1[i+1];
        n_r2[i]      = w_r2[i+1];
        n_rdy1[i]    = w_rdy1[i+1];
        n_rdy2[i]    = w_rdy2[i+1];
        n_fwd1[i]    = w_fwd1[i+1];
        n_fwd2[i]    = w_fwd2[i+1];
        n_src1[i]    = w_src1[i+1];
        n_src2[i]    = w_src2[i+1];
        n_payload[i] = w_payload[i+1];
      end else begin
        n_valid[i]   = w_valid[i];
        n_dst[i]     = w_dst[i];
        n_r1[i]      = w_r1[i];
        n_r2[i]      = w_r2[i];
        n_rdy1[i]    = w_rdy1[i];
        n_rdy2[i]    = w_rdy2[i];
        n_fwd1[i]    = w_fwd1[i];
        n_fwd2[i]    = w_fwd2[i];
        n_src1[i]    = w_src1[i];
        n_src2[i]    = w_src2[i];
        n_payload[i] = w_payload[i];
      end
      if (disp_fire && (CW'(i) == wr_idx)) begin
        n_valid[i]   = 1'b1;
        n_dst[i]     = disp_dst;
        n_r1[i]      = disp_r1;
        n_r2[i]      = disp_r2;
        n_rdy1[i]    = disp_rdy1 | disp_hit1;
        n_rdy2[i]    = disp_rdy2 | disp_hit2;
        n_fwd1[i]    = !disp_rdy1;
        n_fwd2[i]    = !disp_rdy2;
        n_src1[i]    = disp_src1;
        n_src2[i]    = disp_src2;
        n_payload[i] = disp_payload;
      end
      if (flush) n_valid[i] = 1'b0;
    end

    count_n = count_q + CW'(disp_fire) - CW'(issue_fire);
    if (flush) count_n = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_valid[i]   <= 1'b0;
        q_dst[i]     <= '0;
        q_r1[i]      <= '0;
        q_r2[i]      <= '0;
        q_rdy1[i]    <= 1'b0;
        q_rdy2[i]    <= 1'b0;
        q_fwd1[i]    <= 1'b0;
        q_fwd2[i]    <= 1'b0;
        q_src1[i]    <= '0;
        q_src2[i]    <= '0;
        q_payload[i] <= '0;
      end
    end else begin
      count_q <= count_n;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_valid[i]   <= n_valid[i];
        q_dst[i]     <= n_dst[i];
        q_r1[i]      <= n_r1[i];
        q_r2[i]      <= n_r2[i];
        q_rdy1[i]    <= n_rdy1[i];
        q_rdy2[i]    <= n_rdy2[i];
        q_fwd1[i]    <= n_fwd1[i];
        q_fwd2[i]    <= n_fwd2[i];
        q_src1[i]    <= n_src1[i];
        q_src2[i]    <= n_src2[i];
        q_payload[i] <= n_payload[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: issued ops are checked against a scoreboard
// queue filled at dispatch time, plus direct checks of occupancy and handshake flags.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_dst, disp_r1, disp_r2;
  logic        disp_rdy1, disp_rdy2;
  logic [31:0] disp_src1, disp_src2;
  logic [63:0] disp_payload;
  logic [1:0]  wake_valid;
  logic [11:0] wake_id;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  iss_dst, iss_r1, iss_r2;
  logic [31:0] iss_src1, iss_src2;
  logic        iss_fwd_en1, iss_fwd_en2;
  logic [63:0] iss_payload;
  logic [3:0]  count;

  typedef struct {
    logic [5:0]  dst;
    logic [31:0] s1;
    logic [31:0] s2;
    logic        f1;
    logic        f2;
    logic [63:0] pl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_dst(disp_dst), .disp_r1(disp_r1), .disp_r2(disp_r2),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_payload(disp_payload),
    .wake_valid(wake_valid), .wake_id(wake_id),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_dst(iss_dst), .iss_r1(iss_r1), .iss_r2(iss_r2),
    .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_fwd_en1(iss_fwd_en1), .iss_fwd_en2(iss_fwd_en2),
    .iss_payload(iss_payload), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare an issue handshake against the scoreboard head
  task automatic mon();
    exp_t e;
    if (iss_valid && iss_ready && !flush) begin
      chk("issue_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("iss_dst", 64'(iss_dst), 64'(e.dst));
        chk("iss_fwd_en1", 64'(iss_fwd_en1), 64'(e.f1));
        chk("iss_fwd_en2", 64'(iss_fwd_en2), 64'(e.f2));
        chk("iss_payload", iss_payload, e.pl);
        if (!e.f1) chk("iss_src1", 64'(iss_src1), 64'(e.s1));
        if (!e.f2) chk("iss_src2", 64'(iss_src2), 64'(e.s2));
      end
    end
  endtask

  // One clock: check issue before the edge, then return single-cycle pulses to idle
  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
    wake_valid = 2'b00;
    flush      = 1'b0;
    #1;
  endtask

  task automatic disp(input logic [5:0] dst, input logic [5:0] r1, input logic rdy1,
                      input logic [5:0] r2, input logic rdy2,
                      input logic [31:0] s1, input logic [31:0] s2, input logic [63:0] pl);
    disp_valid   = 1'b1;
    disp_dst     = dst;
    disp_r1      = r1;
    disp_r2      = r2;
    disp_rdy1    = rdy1;
    disp_rdy2    = rdy2;
    disp_src1    = s1;
    disp_src2    = s2;
    disp_payload = pl;
  endtask

  task automatic push(input logic [5:0] dst, input logic [31:0] s1, input logic [31:0] s2,
                      input logic f1, input logic f2, input logic [63:0] pl);
    exp_t e;
    e.dst = dst; e.s1 = s1; e.s2 = s2; e.f1 = f1; e.f2 = f2; e.pl = pl;
    sb.push_back(e);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    disp_dst = '0; disp_r1 = '0; disp_r2 = '0; disp_rdy1 = 1'b0; disp_rdy2 = 1'b0;
    disp_src1 = '0; disp_src2 = '0; disp_payload = '0;
    wake_valid = '0; wake_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_iss_valid", 64'(iss_valid), 64'd0);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    resetn = 1'b1;
    step();

    // Ready-at-dispatch op issues one cycle later
    disp(6'd5, 6'd0, 1'b1, 6'd0, 1'b1, 32'h10, 32'h20, 64'hA5);
    push(6'd5, 32'h10, 32'h20, 1'b0, 1'b0, 64'hA5);
    step();
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_iss_dst", 64'(iss_dst), 64'd5);
    chk("t1_iss_src1", 64'(iss_src1), 64'h10);
    chk("t1_fwd1", 64'(iss_fwd_en1), 64'd0);
    chk("t1_fwd2", 64'(iss_fwd_en2), 64'd0);
    chk("t1_count1", 64'(count), 64'd1);
    iss_ready = 1'b1;
    step();
    chk("t1_count0", 64'(count), 64'd0);
    chk("t1_empty", 64'(iss_valid), 64'd0);
    iss_ready = 1'b0;

    // Operand 1 satisfied by a later wake
    disp(6'd7, 6'd3, 1'b0, 6'd0, 1'b1, 32'h0, 32'h22, 64'h7);
    push(6'd7, 32'h0, 32'h22, 1'b1, 1'b0, 64'h7);
    step();
    step();
    chk("t2_waiting", 64'(iss_valid), 64'd0);
    wake_valid = 2'b01;
    wake_id    = {6'd0, 6'd3};
    #1;
`ifdef IQ_FAST_WAKE_EN
    chk("t2_wake_cycle", 64'(iss_valid), 64'd1);
`else
    chk("t2_wake_cycle", 64'(iss_valid), 64'd0);
`endif
    step();
    chk("t2_iss_valid", 64'(iss_valid), 64'd1);
    chk("t2_fwd1", 64'(iss_fwd_en1), 64'd1);
    chk("t2_fwd2", 64'(iss_fwd_en2), 64'd0);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    chk("t2_count0", 64'(count), 64'd0);

    // Fill to full, then drain in age order
    for (int i = 0; i < 8; i++) begin
      disp(6'(i), 6'd0, 1'b1, 6'd0, 1'b1, 32'(i * 3), 32'(i + 100), 64'(i) << 8);
      push(6'(i), 32'(i * 3), 32'(i + 100), 1'b0, 1'b0, 64'(i) << 8);
      step();
    end
    chk("t3_count_full", 64'(count), 64'd8);
    chk("t3_full_ready", 64'(disp_ready), 64'd0);
    iss_ready = 1'b1;
    disp(6'd8, 6'd0, 1'b1, 6'd0, 1'b1, 32'h8, 32'h8, 64'h8);
    #1;
    chk("t3_full_issue_ready", 64'(disp_ready), 64'd0);
    step();
    chk("t3_reassert", 64'(disp_ready), 64'd1);
    chk("t3_count7", 64'(count), 64'd7);
    for (int i = 0; i < 7; i++) step();
    chk("t3_drained", 64'(count), 64'd0);
    iss_ready = 1'b0;

    // Younger ready op bypasses an older waiting one
    disp(6'd1, 6'd9, 1'b0, 6'd0, 1'b1, 32'h0, 32'h11, 64'h1);
    step();
    disp(6'd2, 6'd0, 1'b1, 6'd0, 1'b1, 32'h2, 32'h22, 64'h2);
    step();
    disp(6'd3, 6'd0, 1'b1, 6'd0, 1'b1, 32'h3, 32'h33, 64'h3);
    step();
    push(6'd2, 32'h2, 32'h22, 1'b0, 1'b0, 64'h2);
    push(6'd1, 32'h0, 32'h11, 1'b1, 1'b0, 64'h1);
    push(6'd3, 32'h3, 32'h33, 1'b0, 1'b0, 64'h3);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;
    chk("t4_next_ready", 64'(iss_dst), 64'd3);
    wake_valid = 2'b01;
    wake_id    = {6'd0, 6'd9};
    step();
    chk("t4_oldest_woken", 64'(iss_dst), 64'd1);
    iss_ready = 1'b1;
    step();
    step();
    iss_ready = 1'b0;
    chk("t4_count0", 64'(count), 64'd0);

    // Wake coincident with dispatch is captured
    disp(6'd11, 6'd0, 1'b1, 6'd4, 1'b0, 32'h55, 32'h0, 64'hB);
    wake_valid = 2'b10;
    wake_id    = {6'd4, 6'd0};
    push(6'd11, 32'h55, 32'h0, 1'b0, 1'b1, 64'hB);
    step();
    chk("t5_iss_valid", 64'(iss_valid), 64'd1);
    chk("t5_fwd2", 64'(iss_fwd_en2), 64'd1);
    iss_ready = 1'b1;
    step();
    iss_ready = 1'b0;

    // Flush drops contents and the same-cycle dispatch
    for (int i = 0; i < 3; i++) begin
      disp(6'(20 + i), 6'd0, 1'b1, 6'd0, 1'b1, 32'h1, 32'h1, 64'h1);
      step();
    end
    chk("t6_count3", 64'(count), 64'd3);
    disp(6'd30, 6'd0, 1'b1, 6'd0, 1'b1, 32'h1, 32'h1, 64'h1);
    flush     = 1'b1;
    iss_ready = 1'b1;
    step();
    chk("t6_count0", 64'(count), 64'd0);
    chk("t6_iss_valid", 64'(iss_valid), 64'd0);
    step();
    chk("t6_still_empty", 64'(iss_valid), 64'd0);
    iss_ready = 1'b0;

    // Asynchronous reset mid-cycle
    disp(6'd40, 6'd0, 1'b1, 6'd0, 1'b1, 32'h1, 32'h1, 64'h1);
    step();
    disp(6'd41, 6'd0, 1'b1, 6'd0, 1'b1, 32'h1, 32'h1, 64'h1);
    step();
    chk("t7_count2", 64'(count), 64'd2);
    #2 resetn = 1'b0;
    #1;
    chk("t7_async_count", 64'(count), 64'd0);
    chk("t7_async_iss_valid", 64'(iss_valid), 64'd0);
    chk("t7_async_disp_ready", 64'(disp_ready), 64'd1);
    @(posedge clk);
    #1 resetn = 1'b1;
    step();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
